// File: rtl/eg_mux.sv
// eg_mux: time-multiplexed ADSR envelope generator, one shared datapath swept across NUM_UNITS voices per tick.
// Optional EG_EXP_RELEASE_EN adds an acc>>4 term to the release step for an exponential-like tail.
module eg_mux #(
    parameter int NUM_UNITS   = 4,
    parameter int FIXED_POINT = 8,
    parameter int FRAC_BITS   = 8
) (
    input  logic                             ctl_clk,
    input  logic                             ctl_rst,
    input  logic                             tick,
    input  logic [NUM_UNITS-1:0]             trigger,
    input  logic [FIXED_POINT*NUM_UNITS-1:0] attack_in,
    input  logic [FIXED_POINT*NUM_UNITS-1:0] decay_in,
    input  logic [FIXED_POINT*NUM_UNITS-1:0] sustain_in,
    input  logic [FIXED_POINT*NUM_UNITS-1:0] release_in,
    output logic [FIXED_POINT*NUM_UNITS-1:0] env_out,
    output logic [NUM_UNITS-1:0]             ch_in_use,
    output logic                             busy,
    output logic                             done,
    output logic                             overrun
);
    localparam int ACC_W = FIXED_POINT + FRAC_BITS;
    localparam int IW    = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_UNITS - 1);
    localparam logic [ACC_W:0] MAX = {1'b0, {ACC_W{1'b1}}};
    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;
    state_t               state [NUM_UNITS];
    logic [ACC_W-1:0]     acc   [NUM_UNITS];
    logic [NUM_UNITS-1:0] prev_trig;
    logic [IW-1:0]        idx;
    state_t               cur_st, nxt_st;
    logic [ACC_W-1:0]     cur_acc, nxt_acc;
    logic [FIXED_POINT-1:0] att, dec, sus, rel;
    logic [ACC_W:0]       sus_w, sum, dsub, rstep, rsub;
    logic                 trig, rise, fall;
    always_comb begin
        cur_st  = state[idx];
        cur_acc = acc[idx];
        trig    = trigger[idx];
        rise    = trig & ~prev_trig[idx];
        fall    = ~trig & prev_trig[idx];
        att     = attack_in[idx*FIXED_POINT +: FIXED_POINT];
        dec     = decay_in[idx*FIXED_POINT +: FIXED_POINT];
        sus     = sustain_in[idx*FIXED_POINT +: FIXED_POINT];
        rel     = release_in[idx*FIXED_POINT +: FIXED_POINT];
        sus_w   = {1'b0, sus, {FRAC_BITS{1'b0}}};
        sum     = {1'b0, cur_acc} + (ACC_W+1)'(att);
        dsub    = {1'b0, cur_acc} - (ACC_W+1)'(dec);
`ifdef EG_EXP_RELEASE_EN
        rstep   = (ACC_W+1)'(cur_acc >> 4) + (ACC_W+1)'(rel);
`else
        rstep   = (ACC_W+1)'(rel);
`endif
        // a negative difference shows up as the extra top bit
        rsub    = {1'b0, cur_acc} - rstep;
        nxt_st  = cur_st;
        nxt_acc = cur_acc;
        case (cur_st)
            IDLE: begin
                nxt_acc = '0;
                nxt_st  = rise ? ATTACK : IDLE;
            end
            ATTACK:
                if (fall) nxt_st = RELEASE;
                else if (sum >= MAX || att == '0) begin
                    nxt_acc = MAX[ACC_W-1:0];
                    nxt_st  = DECAY;
                end else nxt_acc = sum[ACC_W-1:0];
            DECAY:
                if (fall) nxt_st = RELEASE;
                else if (dsub[ACC_W] || dsub <= sus_w || dec == '0) begin
                    nxt_acc = sus_w[ACC_W-1:0];
                    nxt_st  = SUSTAIN;
                end else nxt_acc = dsub[ACC_W-1:0];
            SUSTAIN:
                if (fall) nxt_st = RELEASE;
                else nxt_acc = sus_w[ACC_W-1:0];
            RELEASE:
                if (rise) nxt_st = ATTACK;
                else if (rsub[ACC_W] || rsub == '0 || rstep == '0) begin
                    nxt_acc = '0;
                    nxt_st  = IDLE;
                end else nxt_acc = rsub[ACC_W-1:0];
            default: nxt_st = IDLE;
        endcase
    end
    always_ff @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                state[i] <= IDLE;
                acc[i]   <= '0;
            end
            prev_trig <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= busy && idx == LAST;
            if (tick && busy) overrun <= 1'b1;
            if (busy) begin
                state[idx]     <= nxt_st;
                acc[idx]       <= nxt_acc;
                prev_trig[idx] <= trig;
                idx            <= idx == LAST ? '0 : idx + 1'b1;
                busy           <= idx != LAST;
            end else if (tick) begin
                busy <= 1'b1;
                idx  <= '0;
            end
        end
    end
    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_out
        assign env_out[g*FIXED_POINT +: FIXED_POINT] = acc[g][ACC_W-1:FRAC_BITS];
        assign ch_in_use[g] = state[g] != IDLE;
    end
endmodule

// File: tb/tb_eg_mux.sv
// tb_eg_mux: directed-vector bench for eg_mux (default linear-release build, NUM_UNITS=4).
module tb_eg_mux;
    logic        ctl_clk = 1'b0;
    logic        ctl_rst = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  trigger = '0;
    logic [31:0] attack_in = '0, decay_in = '0, sustain_in = '0, release_in = '0;
    logic [31:0] env_out;
    logic [3:0]  ch_in_use;
    logic        busy, done, overrun;
    int          n_cmp = 0, n_err = 0;

    eg_mux dut (
        .ctl_clk(ctl_clk), .ctl_rst(ctl_rst), .tick(tick), .trigger(trigger),
        .attack_in(attack_in), .decay_in(decay_in), .sustain_in(sustain_in),
        .release_in(release_in), .env_out(env_out), .ch_in_use(ch_in_use),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 ctl_clk = ~ctl_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done();
        logic got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge ctl_clk);
            got = done;
        end
        check("sweep_done", {31'b0, got}, 32'd1);
    endtask

    task automatic sweeps(input int n);
        repeat (n) begin
            @(negedge ctl_clk) tick = 1'b1;
            @(negedge ctl_clk) tick = 1'b0;
            wait_done();
        end
    endtask

    initial begin
        int dn = 0, bz = 0;
        repeat (3) begin
            @(negedge ctl_clk) tick = 1'b1;
            @(negedge ctl_clk) tick = 1'b0;
            repeat (6) @(negedge ctl_clk) begin dn += int'(done); bz += int'(busy); end
        end
        check("rst_done", dn, 0);
        check("rst_busy", bz, 0);
        check("rst_env", env_out, 0);
        check("rst_use", {28'b0, ch_in_use}, 0);
        check("rst_ovr", {31'b0, overrun}, 0);

        ctl_rst = 1'b1;
        attack_in[7:0] = 8'h80; decay_in[7:0] = 8'h40;
        sustain_in[7:0] = 8'h10; release_in[7:0] = 8'h80;
        trigger = 4'b0001;
        sweeps(1);
        check("idle_to_att_use", {31'b0, ch_in_use[0]}, 1);
        check("idle_to_att_env", env_out[7:0], 8'h00);
        sweeps(255);
        check("att255", env_out[7:0], 8'h7F);
        sweeps(257);
        check("att512", env_out[7:0], 8'hFF);
        sweeps(3);
        check("dec3", env_out[7:0], 8'hFF);
        sweeps(1);
        check("dec4", env_out[7:0], 8'hFE);
        sweeps(896);
        check("dec900", env_out[7:0], 8'h1E);
        sweeps(60);
        check("dec960", env_out[7:0], 8'h10);
        sweeps(10);
        check("sus_hold", env_out[7:0], 8'h10);
        sustain_in[7:0] = 8'h20;
        sweeps(1);
        check("sus_live", env_out[7:0], 8'h20);
        sustain_in[7:0] = 8'h10;
        sweeps(1);
        check("sus_back", env_out[7:0], 8'h10);

        trigger = 4'b0000;
        sweeps(1);
        check("fall_env", env_out[7:0], 8'h10);
        sweeps(16);
        check("rel16", env_out[7:0], 8'h08);
        trigger = 4'b0001;
        sweeps(1);
        check("retrig_env", env_out[7:0], 8'h08);
        check("retrig_use", {31'b0, ch_in_use[0]}, 1);
        sweeps(3);
        check("retrig_up", env_out[7:0], 8'h09);
        trigger = 4'b0000;
        sweeps(1);
        check("fall2_env", env_out[7:0], 8'h09);
        sweeps(18);
        check("rel18_env", env_out[7:0], 8'h00);
        check("rel18_use", {31'b0, ch_in_use[0]}, 1);
        sweeps(1);
        check("rel_end_use", {31'b0, ch_in_use[0]}, 0);
        check("rel_end_env", env_out[7:0], 8'h00);
        check("no_ovr", {31'b0, overrun}, 0);

        attack_in[15:8] = 8'h00; decay_in[15:8] = 8'h00; sustain_in[15:8] = 8'h30;
        trigger = 4'b0010;
        @(negedge ctl_clk) tick = 1'b1;
        @(negedge ctl_clk) begin
            tick = 1'b0;
            check("t1_busy", {31'b0, busy}, 1);
            check("t1_done", {31'b0, done}, 0);
        end
        @(negedge ctl_clk) tick = 1'b1;
        @(negedge ctl_clk) begin
            tick = 1'b0;
            check("ovr_set", {31'b0, overrun}, 1);
            check("t3_busy", {31'b0, busy}, 1);
        end
        @(negedge ctl_clk) begin
            check("t4_busy", {31'b0, busy}, 1);
            check("t4_done", {31'b0, done}, 0);
        end
        @(negedge ctl_clk) begin
            check("t5_busy", {31'b0, busy}, 0);
            check("t5_done", {31'b0, done}, 1);
            tick = 1'b1;
        end
        @(negedge ctl_clk) begin
            tick = 1'b0;
            check("t6_done", {31'b0, done}, 0);
            check("tick_at_done", {31'b0, busy}, 1);
            check("ch1_use", {31'b0, ch_in_use[1]}, 1);
        end
        wait_done();
        check("att0_env", env_out[15:8], 8'hFF);
        sweeps(1);
        check("dec0_env", env_out[15:8], 8'h30);
        check("ovr_sticky", {31'b0, overrun}, 1);
        check("ch0_quiet", env_out[7:0], 8'h00);

        @(negedge ctl_clk) tick = 1'b1;
        @(negedge ctl_clk) tick = 1'b0;
        ctl_rst = 1'b0;
        dn = 0;
        repeat (8) @(negedge ctl_clk) dn += int'(done);
        check("abort_done", dn, 0);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_env", env_out, 0);
        check("abort_ovr", {31'b0, overrun}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
